// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared phase encoding, default phase durations and the
//               phase-to-green decode for the intersection sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

   typedef enum logic [2:0] {
      CLEAR = 3'd0,
      MAIN  = 3'd1,
      TURN  = 3'd2,
      PED   = 3'd3
   } phase_t;

   localparam int c_main_min_default   = 16;
   localparam int c_turn_time_default  = 8;
   localparam int c_ped_time_default   = 12;
   localparam int c_clear_time_default = 3;
   localparam int c_tw_default         = 8;

   // Green vector ordered {ped, up, down, turn}. Any unknown encoding shows
   // all red so a corrupted state can never light a conflicting pair.
   function automatic logic [3:0] greens_of(input phase_t p);
      logic [3:0] g;
      g = 4'b0000;
      case (p)
         MAIN:    g = 4'b0110;
         TURN:    g = 4'b0101;
         PED:     g = 4'b1000;
         default: g = 4'b0000;
      endcase
      return g;
   endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : Load/decrement-to-zero phase counter. Holds at zero, never
//               wraps. Reset loads RESET_VALUE.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer #(
   parameter int            TW          = 8,
   parameter logic [TW-1:0] RESET_VALUE = '0
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          load,
   input  logic [TW-1:0] value,
   output logic          zero
);

   logic [TW-1:0] r_count;

   // Load has priority; otherwise count down and stick at zero.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_count <= RESET_VALUE;
      end else if (load) begin
         r_count <= value;
      end else if (r_count != '0) begin
         r_count <= r_count - TW'(1);
      end
   end

   assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/signal_controller.sv
`default_nettype none
// ============================================================================
// Module      : signal_controller
// Description : Intersection phase sequencer. Latches pedestrian and turn
//               requests and cycles MAIN / TURN / PED, always passing through
//               an all-red CLEAR phase. Greens are registered from the next
//               state so they are glitch-free and safe from the first cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module signal_controller
   import traffic_pkg::*;
#(
   parameter int MAIN_MIN   = c_main_min_default,
   parameter int TURN_TIME  = c_turn_time_default,
   parameter int PED_TIME   = c_ped_time_default,
   parameter int CLEAR_TIME = c_clear_time_default,
   parameter int TW         = c_tw_default
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pedestrian_button,
   input  logic       turn_sensor,
   output logic       pedestrian_green,
   output logic       up_green,
   output logic       down_green,
   output logic       turn_green,
   output logic [2:0] phase
);

   // Timer reload values: a phase of N cycles counts N-1 down to 0.
   localparam logic [TW-1:0] c_main_load  = TW'(MAIN_MIN - 1);
   localparam logic [TW-1:0] c_turn_load  = TW'(TURN_TIME - 1);
   localparam logic [TW-1:0] c_ped_load   = TW'(PED_TIME - 1);
   localparam logic [TW-1:0] c_clear_load = TW'(CLEAR_TIME - 1);

   phase_t        r_state;
   phase_t        r_target;
   logic          r_ped_req;
   logic          r_turn_req;
   logic [3:0]    r_greens;

   phase_t        w_next_state;
   phase_t        w_next_target;
   logic          w_load;
   logic [TW-1:0] w_load_value;
   logic          w_timer_zero;
   logic          w_enter_ped;
   logic          w_enter_turn;

   phase_timer #(
      .TW          (TW),
      .RESET_VALUE (c_clear_load)
   ) u_phase_timer (
      .clock (clock),
      .reset (reset),
      .load  (w_load),
      .value (w_load_value),
      .zero  (w_timer_zero)
   );

   // Next phase from registered state, timer and request latches only.
   always_comb begin
      w_next_state  = r_state;
      w_next_target = r_target;
      w_load        = 1'b0;
      w_load_value  = c_clear_load;
      case (r_state)
         CLEAR: begin
            if (w_timer_zero) begin
               w_next_state = r_target;
               w_load       = 1'b1;
               case (r_target)
                  MAIN:    w_load_value = c_main_load;
                  TURN:    w_load_value = c_turn_load;
                  PED:     w_load_value = c_ped_load;
                  default: w_load_value = c_clear_load;
               endcase
            end
         end
         MAIN: begin
            // Pedestrian outranks turn; with no request MAIN simply holds.
            if (w_timer_zero && r_ped_req) begin
               w_next_state  = CLEAR;
               w_next_target = PED;
               w_load        = 1'b1;
            end else if (w_timer_zero && r_turn_req) begin
               w_next_state  = CLEAR;
               w_next_target = TURN;
               w_load        = 1'b1;
            end
         end
         TURN, PED: begin
            if (w_timer_zero) begin
               w_next_state  = CLEAR;
               w_next_target = MAIN;
               w_load        = 1'b1;
            end
         end
         default: begin
            // Illegal encoding: recover through an all-red clearance.
            w_next_state  = CLEAR;
            w_next_target = MAIN;
            w_load        = 1'b1;
         end
      endcase
   end

   assign w_enter_ped  = (w_next_state == PED)  && (r_state != PED);
   assign w_enter_turn = (w_next_state == TURN) && (r_state != TURN);

   // Request latches: serving (phase entry) wins over a same-edge set.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ped_req  <= 1'b0;
         r_turn_req <= 1'b0;
      end else begin
         if (w_enter_ped) begin
            r_ped_req <= 1'b0;
         end else if (pedestrian_button && (r_state != PED)) begin
            r_ped_req <= 1'b1;
         end
         if (w_enter_turn) begin
            r_turn_req <= 1'b0;
         end else if (turn_sensor && (r_state != TURN)) begin
            r_turn_req <= 1'b1;
         end
      end
   end

   // State, return target and greens advance together; greens are decoded
   // from the next state so they line up with the phase register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= CLEAR;
         r_target <= MAIN;
         r_greens <= 4'b0000;
      end else begin
         r_state  <= w_next_state;
         r_target <= w_next_target;
         r_greens <= greens_of(w_next_state);
      end
   end

   assign {pedestrian_green, up_green, down_green, turn_green} = r_greens;
   assign phase = r_state;

endmodule
`default_nettype wire

// File: tb/tb_signal_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_signal_controller
// Description : Directed + random bench for signal_controller with a
//               cycle-level reference model feeding an expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signal_controller;

   localparam int MAIN_MIN   = 8;
   localparam int TURN_TIME  = 4;
   localparam int PED_TIME   = 5;
   localparam int CLEAR_TIME = 2;
   localparam int TW         = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       pedestrian_button = 1'b0;
   logic       turn_sensor = 1'b0;
   logic       pedestrian_green;
   logic       up_green;
   logic       down_green;
   logic       turn_green;
   logic [2:0] phase;

   int vectors     = 0;
   int miscompares = 0;
   int ped_cycles  = 0;
   int turn_cycles = 0;

   // Reference model: phase (0 clear,1 main,2 turn,3 ped), return target,
   // cycles spent so far in the current phase, and the request latches.
   int m_phase;
   int m_target;
   int m_cnt;
   bit m_ped;
   bit m_turn;

   typedef struct {
      logic [2:0] ph;
      logic [3:0] g;
   } exp_t;
   exp_t sb[$];

   always #5 clock = ~clock;

   signal_controller #(
      .MAIN_MIN   (MAIN_MIN),
      .TURN_TIME  (TURN_TIME),
      .PED_TIME   (PED_TIME),
      .CLEAR_TIME (CLEAR_TIME),
      .TW         (TW)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .pedestrian_button (pedestrian_button),
      .turn_sensor       (turn_sensor),
      .pedestrian_green  (pedestrian_green),
      .up_green          (up_green),
      .down_green        (down_green),
      .turn_green        (turn_green),
      .phase             (phase)
   );

   function automatic logic [3:0] exp_greens(input int p);
      logic [3:0] g;
      case (p)
         1:       g = 4'b0110;
         2:       g = 4'b0101;
         3:       g = 4'b1000;
         default: g = 4'b0000;
      endcase
      return g;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase  = 0;
      m_target = 1;
      m_cnt    = 0;
      m_ped    = 1'b0;
      m_turn   = 1'b0;
   endtask

   // Advance the model by one clock edge with the given sampled inputs.
   task automatic model_step(input bit b, input bit s);
      int nphase;
      int ntarget;
      int ncnt;
      bit nped;
      bit nturn;
      bit expired;
      int dur;
      nphase  = m_phase;
      ntarget = m_target;
      ncnt    = m_cnt + 1;
      nped    = m_ped;
      nturn   = m_turn;
      case (m_phase)
         1:       dur = MAIN_MIN;
         2:       dur = TURN_TIME;
         3:       dur = PED_TIME;
         default: dur = CLEAR_TIME;
      endcase
      expired = (m_cnt >= dur - 1);
      if (m_phase == 0 && expired) begin
         nphase = m_target;
      end else if (m_phase == 1 && expired && m_ped) begin
         nphase = 0; ntarget = 3;
      end else if (m_phase == 1 && expired && m_turn) begin
         nphase = 0; ntarget = 2;
      end else if ((m_phase == 2 || m_phase == 3) && expired) begin
         nphase = 0; ntarget = 1;
      end
      if (nphase != m_phase) ncnt = 0;
      else if (ncnt > 1000) ncnt = 1000;
      if (b && m_phase != 3) nped = 1'b1;
      if (s && m_phase != 2) nturn = 1'b1;
      if (nphase == 3 && m_phase != 3) nped = 1'b0;
      if (nphase == 2 && m_phase != 2) nturn = 1'b0;
      m_phase  = nphase;
      m_target = ntarget;
      m_cnt    = ncnt;
      m_ped    = nped;
      m_turn   = nturn;
   endtask

   // Drive inputs, predict, clock once, then compare away from the edge.
   task automatic step(input bit b, input bit s);
      exp_t e;
      pedestrian_button = b;
      turn_sensor       = s;
      model_step(b, s);
      e.ph = 3'(m_phase);
      e.g  = exp_greens(m_phase);
      sb.push_back(e);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check("phase", {29'd0, phase}, {29'd0, e.ph});
         check("greens", {28'd0, pedestrian_green, up_green, down_green, turn_green}, {28'd0, e.g});
      end
      check("inv_ped_vs_main", {31'd0, pedestrian_green & (up_green | down_green)}, 32'd0);
      check("inv_turn_vs_down", {31'd0, turn_green & down_green}, 32'd0);
      if (pedestrian_green === 1'b1) ped_cycles++;
      if (turn_green === 1'b1) turn_cycles++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      // Reset state while reset is held.
      repeat (2) @(posedge clock);
      #1;
      check("reset_phase", {29'd0, phase}, 32'd0);
      check("reset_greens", {28'd0, pedestrian_green, up_green, down_green, turn_green}, 32'd0);
      reset = 1'b1;

      // 1: two CLEAR cycles then MAIN held with no requests.
      idle(22);
      check("main_held", {29'd0, phase}, 32'd1);

      // 2: single button pulse deep into MAIN.
      ped_cycles = 0;
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      check("ped_latency_clear", {29'd0, phase}, 32'd0);
      idle(9);
      check("ped_duration", ped_cycles, 32'd5);

      // 3: turn pulse early in MAIN waits for the minimum.
      turn_cycles = 0;
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      idle(25);
      check("turn_duration", turn_cycles, 32'd4);

      // 4: both requests on one edge: PED, MAIN minimum, then TURN, once each.
      ped_cycles  = 0;
      turn_cycles = 0;
      step(1'b1, 1'b1);
      idle(40);
      check("both_ped_once", ped_cycles, 32'd5);
      check("both_turn_once", turn_cycles, 32'd4);

      // 5a: button held through PED but released before PED exit.
      ped_cycles = 0;
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
      idle(30);
      check("held_ped_single", ped_cycles, 32'd5);

      // 5b: button held past PED exit -> PED recurs after MAIN minimum.
      ped_cycles = 0;
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
      idle(20);
      check("held_ped_repeat", ped_cycles, 32'd10);

      // 6: asynchronous reset in the middle of PED with a turn request pending.
      turn_cycles = 0;
      step(1'b1, 1'b0);
      idle(3);
      step(1'b0, 1'b1);
      check("in_ped_before_reset", {29'd0, phase}, 32'd3);
      pedestrian_button = 1'b0;
      turn_sensor       = 1'b0;
      #3;
      reset = 1'b0;
      #1;
      check("async_reset_greens", {28'd0, pedestrian_green, up_green, down_green, turn_green}, 32'd0);
      check("async_reset_phase", {29'd0, phase}, 32'd0);
      model_reset();
      @(posedge clock);
      #1;
      reset = 1'b1;
      idle(15);
      check("reset_cleared_turn", turn_cycles, 32'd0);

      // Random sparse requests with invariants checked every cycle.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 11) == 0), ($urandom_range(0, 9) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
